dmem_stage: RTL and testbench

- Parametrised data-memory pipeline stage: byte-addressed, word-organised data RAM plus the MEM/WB pipeline register.
- Supports byte/half/word loads and stores with correct lane selection and sign extension.
- Configurable load latency with a stall handshake back to EX; optional alignment/range fault detection.
- Sits between the execute stage and writeback in the riscv_pkg core.

---
 rtl/dmem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_dmem_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage.sv
// Data-memory pipeline stage: byte-addressed word RAM, load/store lane handling and MEM/WB register.
// Optional alignment/range fault detection is enabled with `define DMEM_FAULT_EN.

package riscv_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } operation_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        valid;
    } rd_port_t;
endpackage

module dmem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_WORDS = 2048,
    parameter int unsigned LOAD_LAT  = 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  operation_e      operation_i,
    input  rd_port_t        rd_port_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output rd_port_t        rd_port_o,
    output logic            fault_o,
    output logic [XLEN-1:0] fault_addr_o
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CW    = 2;
    localparam bit          MULTI = (LOAD_LAT > 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [AW-1:0]   widx;
    logic [XLEN-1:0] rdata;
    logic            is_load, is_store, req_fault;
    logic [3:0]      be;
    logic [XLEN-1:0] wd;
    logic            we, capture, stall_c;

    operation_e      hold_op;
    logic [1:0]      hold_off;
    logic [XLEN-1:0] hold_pc, hold_instr, hold_word;
    rd_port_t        hold_rd;

    logic            valid_d, fault_d;
    logic [XLEN-1:0] pc_d, instr_d, faddr_d;
    rd_port_t        rd_d;

    assign widx     = addr_i[AW+1:2];
    assign rdata    = mem[widx];
    assign is_load  = operation_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    assign is_store = operation_i inside {OP_SB, OP_SH, OP_SW};

`ifdef DMEM_FAULT_EN
    logic misalign, range_err;
    assign misalign  = ((operation_i inside {OP_LH, OP_LHU, OP_SH}) && addr_i[0])
                     || ((operation_i inside {OP_LW, OP_SW}) && (addr_i[1:0] != 2'b00));
    assign range_err = addr_i >= XLEN'(MEM_WORDS * 4);
    assign req_fault = valid_i && (is_load || is_store) && (misalign || range_err);
`else
    // Upper address bits are dropped so the word index wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[XLEN-1:AW+2];
    assign req_fault      = 1'b0;
`endif

    // Lane selection and extension of a loaded word.
    function automatic logic [XLEN-1:0] load_ext(operation_e op, logic [1:0] off,
                                                 logic [XLEN-1:0] w);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            default: res = w;
        endcase
        return res;
    endfunction

    // Store byte enables with the data replicated across lanes.
    always_comb begin
        be = 4'b0000;
        wd = wdata_i;
        case (operation_i)
            OP_SB: begin
                be = 4'b0001 << addr_i[1:0];
                wd = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                be = addr_i[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_i[15:0]}};
            end
            OP_SW:   be = 4'b1111;
            default: ;
        endcase
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            if (be[0]) mem[widx][7:0]   <= wd[7:0];
            if (be[1]) mem[widx][15:8]  <= wd[15:8];
            if (be[2]) mem[widx][23:16] <= wd[23:16];
            if (be[3]) mem[widx][31:24] <= wd[31:24];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        stall_c = 1'b0;
        we      = 1'b0;
        valid_d = 1'b0;
        pc_d    = pc_i;
        instr_d = instr_i;
        rd_d    = '0;
        fault_d = 1'b0;
        faddr_d = '0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (MULTI && is_load && !req_fault) begin
                        stall_c = 1'b1;
                        capture = 1'b1;
                        cnt_d   = CW'(LOAD_LAT - 1);
                        state_d = BUSY;
                    end else begin
                        valid_d = 1'b1;
                        rd_d    = rd_port_i;
                        if (is_load)  rd_d.data  = load_ext(operation_i, addr_i[1:0], rdata);
                        if (is_store) rd_d.valid = 1'b0;
                        if (req_fault) begin
                            rd_d.valid = 1'b0;
                            fault_d    = 1'b1;
                            faddr_d    = addr_i;
                        end
                        we = is_store && !req_fault;
                    end
                end
            end
            BUSY: begin
                if (cnt_q > CW'(1)) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CW'(1);
                end else begin
                    valid_d   = 1'b1;
                    pc_d      = hold_pc;
                    instr_d   = hold_instr;
                    rd_d      = hold_rd;
                    rd_d.data = load_ext(hold_op, hold_off, hold_word);
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held off while in reset so a pending load does not stall upstream.
    assign stall_o = rstn_i & stall_c;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_op      <= OP_NOP;
            hold_off     <= '0;
            hold_pc      <= '0;
            hold_instr   <= '0;
            hold_word    <= '0;
            hold_rd      <= '0;
            valid_o      <= 1'b0;
            pc_o         <= '0;
            instr_o      <= '0;
            rd_port_o    <= '0;
            fault_o      <= 1'b0;
            fault_addr_o <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_o      <= valid_d;
            pc_o         <= pc_d;
            instr_o      <= instr_d;
            rd_port_o    <= rd_d;
            fault_o      <= fault_d;
            fault_addr_o <= faddr_d;
            if (capture) begin
                hold_op    <= operation_i;
                hold_off   <= addr_i[1:0];
                hold_pc    <= pc_i;
                hold_instr <= instr_i;
                hold_word  <= rdata;
                hold_rd    <= rd_port_i;
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: one LOAD_LAT=1 and one LOAD_LAT=3 instance against a byte-array model.
module tb_dmem_stage;
    import riscv_pkg::*;

    localparam int unsigned MW   = 2048;
    localparam int unsigned MB   = MW * 4;
    localparam int unsigned LAT3 = 3;

    logic clk, rstn;
    logic v1, s1, vo1, f1, v3, s3, vo3, f3;
    logic [31:0] pc1, instr1, addr1, wd1, pco1, io1, fa1;
    logic [31:0] pc3, instr3, addr3, wd3, pco3, io3, fa3;
    operation_e op1, op3;
    rd_port_t rdi1, rdo1, rdi3, rdo3;
    int checks, failures;
    logic [7:0] ref1 [MB];
    logic [7:0] ref3 [MB];

    dmem_stage #(.XLEN(32), .MEM_WORDS(MW), .LOAD_LAT(1)) u_l1 (
        .clk_i(clk), .rstn_i(rstn), .valid_i(v1), .pc_i(pc1), .instr_i(instr1),
        .operation_i(op1), .rd_port_i(rdi1), .addr_i(addr1), .wdata_i(wd1),
        .stall_o(s1), .valid_o(vo1), .pc_o(pco1), .instr_o(io1), .rd_port_o(rdo1),
        .fault_o(f1), .fault_addr_o(fa1));

    dmem_stage #(.XLEN(32), .MEM_WORDS(MW), .LOAD_LAT(LAT3)) u_l3 (
        .clk_i(clk), .rstn_i(rstn), .valid_i(v3), .pc_i(pc3), .instr_i(instr3),
        .operation_i(op3), .rd_port_i(rdi3), .addr_i(addr3), .wdata_i(wd3),
        .stall_o(s3), .valid_o(vo3), .pc_o(pco3), .instr_o(io3), .rd_port_o(rdo3),
        .fault_o(f3), .fault_addr_o(fa3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit is_ld(operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic bit is_st(operation_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Byte-level memory model: stores update bytes, loads assemble and extend them.
    task automatic model_apply(input bit which, input logic vin, input operation_e op,
                               input logic [31:0] a, input logic [31:0] wd, input rd_port_t rin,
                               output rd_port_t rexp, output logic fexp);
        int unsigned sz, base, ua;
        logic [31:0] val;
        logic [7:0]  byt;
        ua   = a;
        sz   = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        fexp = 1'b0;
`ifdef DMEM_FAULT_EN
        if ((is_ld(op) || is_st(op)) && ((ua % sz) != 0 || ua >= MB)) fexp = 1'b1;
`endif
        base = (ua - (ua % sz)) % MB;
        rexp = rin;
        if (!vin) begin
            rexp.valid = 1'b0;
            fexp       = 1'b0;
        end else begin
            if (is_st(op)) begin
                rexp.valid = 1'b0;
                if (!fexp) begin
                    for (int unsigned i = 0; i < sz; i++) begin
                        if (which) ref3[base + i] = wd[8*i +: 8];
                        else       ref1[base + i] = wd[8*i +: 8];
                    end
                end
            end
            if (is_ld(op) && !fexp) begin
                val = '0;
                for (int unsigned i = 0; i < sz; i++) begin
                    byt = which ? ref3[base + i] : ref1[base + i];
                    val = val | (32'(byt) << (8 * i));
                end
                if ((op == OP_LB || op == OP_LH) && val[8*sz-1])
                    val = val | (32'hFFFF_FFFF << (8 * sz));
                rexp.data = val;
            end
            if (fexp) rexp.valid = 1'b0;
        end
    endtask

    task automatic exec1(input logic vin, input operation_e op, input logic [31:0] a,
                         input logic [31:0] wd, output rd_port_t rexp, output logic fexp);
        rd_port_t rin;
        rin.addr  = 5'($urandom);
        rin.data  = $urandom;
        rin.valid = !is_st(op);
        v1 = vin; op1 = op; addr1 = a; wd1 = wd;
        pc1 = $urandom; instr1 = $urandom; rdi1 = rin;
        model_apply(1'b0, vin, op, a, wd, rin, rexp, fexp);
        @(posedge clk); #1;
    endtask

    task automatic drive3(input logic vin, input operation_e op, input logic [31:0] a,
                          input logic [31:0] wd, output rd_port_t rexp, output logic fexp);
        rd_port_t rin;
        rin.addr  = 5'($urandom);
        rin.data  = $urandom;
        rin.valid = !is_st(op);
        v3 = vin; op3 = op; addr3 = a; wd3 = wd;
        pc3 = $urandom; instr3 = $urandom; rdi3 = rin;
        model_apply(1'b1, vin, op, a, wd, rin, rexp, fexp);
    endtask

    // Present an op and hold it until the edge on which stall is low.
    task automatic exec3(input logic vin, input operation_e op, input logic [31:0] a,
                         input logic [31:0] wd, output rd_port_t rexp, output logic fexp,
                         output int stalls, output bit tmo);
        logic st_seen;
        drive3(vin, op, a, wd, rexp, fexp);
        stalls = 0;
        tmo    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            st_seen = s3;
            @(posedge clk); #1;
            if (!st_seen) begin
                tmo = 1'b0;
                break;
            end
            stalls++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        v1 = 0; op1 = OP_NOP; addr1 = '0; wd1 = '0; pc1 = '0; instr1 = '0; rdi1 = '0;
        v3 = 0; op3 = OP_NOP; addr3 = '0; wd3 = '0; pc3 = '0; instr3 = '0; rdi3 = '0;
        @(posedge clk); #1;
        checks++;
        if (vo1 !== 1'b0 || vo3 !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b%b exp=00", vo1, vo3);
        end
        checks++;
        if (rdo1 !== '0 || rdo3 !== '0) begin
            failures++; $display("FAIL reset_rd got=%h/%h exp=0", rdo1, rdo3);
        end
        checks++;
        if ({pco1, io1, pco3, io3} !== '0) begin
            failures++; $display("FAIL reset_pc_instr got=%h %h %h %h exp=0", pco1, io1, pco3, io3);
        end
        checks++;
        if ({s1, s3, f1, f3} !== 4'b0 || {fa1, fa3} !== '0) begin
            failures++; $display("FAIL reset_stall_fault got=%b%b%b%b fa=%h/%h exp=0", s1, s3, f1, f3, fa1, fa3);
        end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lanes();
        rd_port_t r;
        logic f;
        operation_e ops [4];
        logic [31:0] adr [4];
        logic [31:0] exp [4];
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
        adr = '{32'h10, 32'h10, 32'h12, 32'h12};
        exp = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8000, 32'h0000_8000};
        exec1(1'b1, OP_SW, 32'h10, 32'h8000_00F1, r, f);
        checks++;
        if (vo1 !== 1'b1 || rdo1.valid !== 1'b0) begin
            failures++; $display("FAIL store_rd_valid got=%b/%b exp=1/0", vo1, rdo1.valid);
        end
        for (int i = 0; i < 4; i++) begin
            exec1(1'b1, ops[i], adr[i], $urandom, r, f);
            checks++;
            if (rdo1.data !== exp[i] || rdo1.valid !== 1'b1 || rdo1.addr !== rdi1.addr) begin
                failures++; $display("FAIL lane_%s got=%h exp=%h", ops[i].name(), rdo1.data, exp[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        rd_port_t r;
        logic f;
        exec1(1'b1, OP_SW, 32'h20, 32'h1122_3344, r, f);
        exec1(1'b1, OP_SB, 32'h21, 32'h5566_77AA, r, f);
        exec1(1'b1, OP_LW, 32'h20, $urandom, r, f);
        checks++;
        if (rdo1.data !== 32'h1122_AA44) begin
            failures++; $display("FAIL sb_merge got=%h exp=1122aa44", rdo1.data);
        end
    endtask

    task automatic test_bubble();
        rd_port_t r;
        logic f;
        exec1(1'b0, OP_SW, 32'h10, 32'h1234_5678, r, f);
        checks++;
        if (vo1 !== 1'b0 || rdo1.valid !== 1'b0) begin
            failures++; $display("FAIL bubble got=%b/%b exp=0/0", vo1, rdo1.valid);
        end
        exec1(1'b1, OP_LW, 32'h10, $urandom, r, f);
        checks++;
        if (rdo1.data !== 32'h8000_00F1) begin
            failures++; $display("FAIL bubble_no_write got=%h exp=800000f1", rdo1.data);
        end
        exec1(1'b1, OP_ADD, $urandom, $urandom, r, f);
        checks++;
        if (vo1 !== 1'b1 || rdo1 !== rdi1 || pco1 !== pc1) begin
            failures++; $display("FAIL alu_pass got=%h exp=%h", rdo1, rdi1);
        end
    endtask

    task automatic test_latency();
        rd_port_t r;
        logic f;
        int st;
        bit tmo;
        exec3(1'b1, OP_SW, 32'h40, 32'hDEAD_BEEF, r, f, st, tmo);
        drive3(1'b1, OP_LW, 32'h40, $urandom, r, f);
        #1; checks++;
        if (s3 !== 1'b1) begin failures++; $display("FAIL lat_stall_c1 got=%b exp=1", s3); end
        @(posedge clk); #1; checks++;
        if (vo3 !== 1'b0) begin failures++; $display("FAIL lat_bubble1 got=%b exp=0", vo3); end
        #1; checks++;
        if (s3 !== 1'b1) begin failures++; $display("FAIL lat_stall_c2 got=%b exp=1", s3); end
        @(posedge clk); #1; checks++;
        if (vo3 !== 1'b0) begin failures++; $display("FAIL lat_bubble2 got=%b exp=0", vo3); end
        #1; checks++;
        if (s3 !== 1'b0) begin failures++; $display("FAIL lat_release got=%b exp=0", s3); end
        @(posedge clk); #1; checks++;
        if (vo3 !== 1'b1 || rdo3.data !== 32'hDEAD_BEEF || rdo3 !== r || pco3 !== pc3) begin
            failures++; $display("FAIL lat_load got=%b %h exp=1 deadbeef", vo3, rdo3.data);
        end
        drive3(1'b1, OP_ADD, $urandom, $urandom, r, f);
        #1; checks++;
        if (s3 !== 1'b0) begin failures++; $display("FAIL lat_add_stall got=%b exp=0", s3); end
        @(posedge clk); #1; checks++;
        if (vo3 !== 1'b1 || rdo3 !== rdi3) begin
            failures++; $display("FAIL lat_add got=%h exp=%h", rdo3, rdi3);
        end
    endtask

    task automatic test_reset_busy();
        rd_port_t r;
        logic f;
        int st;
        bit tmo;
        drive3(1'b1, OP_LW, 32'h40, $urandom, r, f);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1; checks++;
        if (s3 !== 1'b0 || vo3 !== 1'b0 || rdo3 !== '0) begin
            failures++; $display("FAIL rst_busy got=stall%b valid%b rd%h exp=0", s3, vo3, rdo3);
        end
        #1 rstn = 1'b1;
        exec3(1'b1, OP_LW, 32'h40, $urandom, r, f, st, tmo);
        checks++;
        if (tmo || st != int'(LAT3 - 1) || vo3 !== 1'b1 || rdo3.data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL rst_busy_retry got=tmo%0d stalls%0d %h exp=0 2 deadbeef", tmo, st, rdo3.data);
        end
    endtask

`ifdef DMEM_FAULT_EN
    task automatic test_fault();
        rd_port_t r;
        logic f;
        int st;
        bit tmo;
        exec1(1'b1, OP_SW, 32'h40, 32'h1111_1111, r, f);
        exec1(1'b1, OP_SW, 32'h42, 32'h2222_2222, r, f);
        checks++;
        if (f1 !== 1'b1 || fa1 !== 32'h42 || rdo1.valid !== 1'b0) begin
            failures++; $display("FAIL fault_sw got=%b %h %b exp=1 42 0", f1, fa1, rdo1.valid);
        end
        exec1(1'b1, OP_LW, 32'h40, $urandom, r, f);
        checks++;
        if (f1 !== 1'b0 || rdo1.data !== 32'h1111_1111) begin
            failures++; $display("FAIL fault_no_write got=%b %h exp=0 11111111", f1, rdo1.data);
        end
        exec3(1'b1, OP_LW, 32'h2000, $urandom, r, f, st, tmo);
        checks++;
        if (tmo || st != 0 || f3 !== 1'b1 || fa3 !== 32'h2000 || rdo3.valid !== 1'b0) begin
            failures++; $display("FAIL fault_range got=stalls%0d f%b %h v%b exp=0 1 2000 0", st, f3, fa3, rdo3.valid);
        end
    endtask
`else
    task automatic test_wrap();
        rd_port_t r;
        logic f;
        int st;
        bit tmo;
        exec1(1'b1, OP_SW, 32'h2010, 32'hCAFE_F00D, r, f);
        exec1(1'b1, OP_LW, 32'h10, $urandom, r, f);
        checks++;
        if (f1 !== 1'b0 || rdo1.data !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL wrap got=%b %h exp=0 cafef00d", f1, rdo1.data);
        end
        exec1(1'b1, OP_LH, 32'h13, $urandom, r, f);
        checks++;
        if (rdo1.data !== 32'hFFFF_CAFE) begin
            failures++; $display("FAIL align_down got=%h exp=ffffcafe", rdo1.data);
        end
        exec3(1'b1, OP_LW, 32'h2000, $urandom, r, f, st, tmo);
        checks++;
        if (tmo || st != int'(LAT3 - 1) || f3 !== 1'b0 || fa3 !== '0) begin
            failures++; $display("FAIL no_fault got=stalls%0d f%b %h exp=2 0 0", st, f3, fa3);
        end
    endtask
`endif

    task automatic test_random_lat1();
        rd_port_t r;
        logic f, vin;
        logic [31:0] a;
        operation_e op;
        for (int w = 0; w < 64; w++) exec1(1'b1, OP_SW, 32'(w * 4), $urandom, r, f);
        for (int n = 0; n < 200; n++) begin
            a   = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = a + 32'h2000;
            vin = ($urandom_range(0, 7) != 0);
            op  = operation_e'($urandom_range(0, 9));
            exec1(vin, op, a, $urandom, r, f);
            checks++;
            if (vo1 !== vin || f1 !== f) begin
                failures++; $display("FAIL rnd1_ctl n=%0d got=v%b f%b exp=v%b f%b", n, vo1, f1, vin, f);
            end
            checks++;
            if (!vin) begin
                if (rdo1.valid !== 1'b0) begin
                    failures++; $display("FAIL rnd1_bubble n=%0d got=%b exp=0", n, rdo1.valid);
                end
            end else if (f) begin
                if (rdo1.valid !== 1'b0 || fa1 !== a) begin
                    failures++; $display("FAIL rnd1_fault n=%0d got=%b %h exp=0 %h", n, rdo1.valid, fa1, a);
                end
            end else if (rdo1 !== r || pco1 !== pc1 || io1 !== instr1) begin
                failures++; $display("FAIL rnd1_data n=%0d %s @%h got=%h exp=%h", n, op.name(), a, rdo1, r);
            end
        end
    endtask

    task automatic test_random_lat3();
        rd_port_t r;
        logic f, vin;
        logic [31:0] a;
        operation_e op;
        int st, est;
        bit tmo;
        for (int w = 0; w < 64; w++) exec3(1'b1, OP_SW, 32'(w * 4), $urandom, r, f, st, tmo);
        for (int n = 0; n < 80; n++) begin
            a   = 32'($urandom_range(0, 255));
            vin = ($urandom_range(0, 7) != 0);
            op  = operation_e'($urandom_range(0, 9));
            exec3(vin, op, a, $urandom, r, f, st, tmo);
            est = (vin && is_ld(op) && !f) ? int'(LAT3 - 1) : 0;
            checks++;
            if (tmo || st != est || vo3 !== vin || f3 !== f) begin
                failures++; $display("FAIL rnd3_ctl n=%0d got=tmo%0d st%0d v%b f%b exp=0 %0d %b %b", n, tmo, st, vo3, f3, est, vin, f);
            end
            checks++;
            if (vin && !f && (rdo3 !== r || pco3 !== pc3 || io3 !== instr3)) begin
                failures++; $display("FAIL rnd3_data n=%0d %s @%h got=%h exp=%h", n, op.name(), a, rdo3, r);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lanes();
        test_byte_store();
        test_bubble();
        test_latency();
        test_reset_busy();
`ifdef DMEM_FAULT_EN
        test_fault();
`else
        test_wrap();
`endif
        test_random_lat1();
        test_random_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
